// File: rtl/div_unit_if.sv
// Handshake and operand/result bundle between the EX-stage pipeline control
// and the iterative divider.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic             flush;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, is_signed, flush, dividend, divisor,
        input  busy, done, quotient, remainder
    );

    modport slave (
        input  start, is_signed, flush, dividend, divisor,
        output busy, done, quotient, remainder
    );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU: quotient feeds LO,
// remainder feeds HI. Fixed latency of WIDTH+2 cycles from start to done.
module div_unit #(
    parameter int WIDTH      = 32,
    parameter int ITER_CNT_W = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    div_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    localparam logic [ITER_CNT_W-1:0] LAST_CNT = ITER_CNT_W'(WIDTH);

    state_t                state_q, state_d;
    logic [ITER_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]      rem_q, rem_d;
    logic [WIDTH-1:0]      quo_q, quo_d;
    logic [WIDTH-1:0]      dvsr_q, dvsr_d;
    logic                  q_neg_q, q_neg_d;
    logic                  r_neg_q, r_neg_d;
    logic [WIDTH-1:0]      quot_q, quot_d;
    logic [WIDTH-1:0]      remo_q, remo_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  a_neg, b_neg;
    logic [WIDTH-1:0]      abs_a, abs_b;
    logic [WIDTH:0]        shifted, trial;

    assign a_neg = bus.is_signed & bus.dividend[WIDTH-1];
    assign b_neg = bus.is_signed & bus.divisor[WIDTH-1];
    assign abs_a = a_neg ? -bus.dividend : bus.dividend;
    assign abs_b = b_neg ? -bus.divisor  : bus.divisor;

    // Bring the next dividend bit into the partial remainder, then trial-subtract
    // with one extra bit so the borrow tells us whether to restore.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvsr_q};

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        quot_d  = quot_q;
        remo_d  = remo_q;

        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        quo_d   = abs_a;
                        dvsr_d  = abs_b;
                        rem_d   = '0;
                        q_neg_d = a_neg ^ b_neg;
                        r_neg_d = a_neg;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
                CALC: begin
                    cnt_d = cnt_q + ITER_CNT_W'(1);
                    // The count reaches WIDTH after the last quotient bit; that
                    // slot only hands over to FIX, keeping latency at WIDTH+2.
                    if (cnt_q == LAST_CNT) begin
                        state_d = FIX;
                    end else if (!trial[WIDTH]) begin
                        rem_d = trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
                    quot_d  = q_neg_q ? -quo_q : quo_q;
                    remo_d  = r_neg_q ? -rem_q : rem_q;
                    state_d = DONE;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == CALC) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = remo_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: table of DIV/DIVU vectors through a
// result scoreboard, plus hand-written ignore/flush/reset sequences.
module tb_div_unit;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        string       name;
    } exp_t;

    logic clk;
    logic rst_n;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32), .ITER_CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_pass     = 0;
    int   n_total    = 0;
    int   done_count = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[10];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Results are compared when the DUT announces them, against the queue
    // filled at launch time.
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            done_count++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_q"}, bus.quotient, mon_e.q);
                check({mon_e.name, "_r"}, bus.remainder, mon_e.r);
            end
        end
    end

    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic push, input logic [31:0] q, input logic [31:0] r,
                          input string name);
        @(negedge clk);
        bus.is_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.start     = 1'b1;
        if (push) sb.push_back('{q: q, r: r, name: name});
        @(negedge clk);
        bus.start     = 1'b0;
        bus.dividend  = $urandom;
        bus.divisor   = $urandom;
        bus.is_signed = 1'($urandom_range(0, 1));
    endtask

    // Called at the first negedge after the start edge; leaves us at the
    // negedge where done is high.
    task automatic wait_done(input string name, output int waited, output int busy_cycles);
        waited      = 0;
        busy_cycles = 0;
        while (bus.done !== 1'b1 && waited < 200) begin
            if (bus.busy === 1'b1) busy_cycles++;
            @(negedge clk);
            waited++;
        end
        check({name, "_done_seen"}, 32'(bus.done), 32'd1);
    endtask

    task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
        bus.is_signed = 1'b0;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    task automatic run_op(input vec_t v);
        int w;
        int bc;
        launch(v.sgn, v.a, v.b, 1'b1, v.q, v.r, v.name);
        wait_done(v.name, w, bc);
        check({v.name, "_latency"}, 32'(w), 32'd34);
        check({v.name, "_busy_cycles"}, 32'(bc), 32'd34);
        check({v.name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        check({v.name, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int bc;
        int dc;

        vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        "divu_100_7"};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, "div_m7_2"};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        "div_7_m2"};
        vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0,        "div_ovf"};
        vecs[4] = '{1'b0, 32'h12345678,   32'd0,        32'hFFFFFFFF, 32'h12345678, "divu_by0"};
        vecs[5] = '{1'b1, 32'hFFFFFFFB,   32'd0,        32'd1,        32'hFFFFFFFB, "div_m5_by0"};
        vecs[6] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, "div_m7_m2"};
        vecs[7] = '{1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'd0,        "divu_max_1"};
        vecs[8] = '{1'b0, 32'd5,          32'd9,        32'd0,        32'd5,        "divu_5_9"};
        vecs[9] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 32'd0,        32'h80000000, "divu_big"};

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.flush     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_q", bus.quotient, 32'd0);
        check("reset_r", bus.remainder, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_op(vecs[i]);

        // flush together with start in IDLE launches nothing
        dc = done_count;
        @(negedge clk);
        bus.dividend = 32'd7;
        bus.divisor  = 32'd1;
        bus.start    = 1'b1;
        bus.flush    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.flush    = 1'b0;
        check("flush_start_busy", 32'(bus.busy), 32'd0);
        repeat (40) @(negedge clk);
        check("flush_start_no_done", 32'(done_count), 32'(dc));

        // starts while busy and during DONE are dropped
        dc = done_count;
        launch(1'b0, 32'd20, 32'd3, 1'b1, 32'd6, 32'd2, "ign_20_3");
        repeat (4) @(negedge clk);
        pulse_start(32'd9, 32'd4);
        repeat (14) @(negedge clk);
        pulse_start(32'd9, 32'd4);
        wait_done("ign_20_3", w, bc);
        pulse_start(32'd9, 32'd4);
        check("start_in_done_ignored", 32'(bus.busy), 32'd0);
        repeat (40) @(negedge clk);
        check("ign_single_done", 32'(done_count), 32'(dc + 1));
        run_op('{1'b0, 32'd9, 32'd4, 32'd2, 32'd1, "divu_9_4"});

        // flush mid-CALC keeps previous outputs and produces no done
        dc = done_count;
        launch(1'b0, 32'd50, 32'd5, 1'b0, 32'd0, 32'd0, "flushed");
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", 32'(bus.busy), 32'd0);
        check("flush_done", 32'(bus.done), 32'd0);
        check("flush_hold_q", bus.quotient, 32'd2);
        check("flush_hold_r", bus.remainder, 32'd1);
        repeat (40) @(negedge clk);
        check("flush_no_done", 32'(done_count), 32'(dc));
        run_op('{1'b0, 32'd50, 32'd5, 32'd10, 32'd0, "divu_50_5"});

        // asynchronous reset in the middle of CALC
        launch(1'b0, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0, "reset_abort");
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_q", bus.quotient, 32'd0);
        check("arst_r", bus.remainder, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op('{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "after_reset"});

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
